// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared constants for the register-file writeback scheduler: widths,
// the fixed jal link register and the requester slot numbering.
package regfile_wb_scheduler_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;

  localparam logic [4:0] REG_LINK = 5'd31;

  localparam int REQ_MEM = 0;
  localparam int REQ_LNK = 1;
  localparam int REQ_ALU = 2;
  localparam int NREQ    = 3;

endpackage

// File: rtl/regfile_wb_scheduler_wb_scoreboard.sv
// Busy bits for registers awaiting a load return, with three lookup ports
// used by decode to detect RAW/WAW hazards.
module regfile_wb_scheduler_wb_scoreboard
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int AW = ADDR_W
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            set_en,
  input  logic [AW-1:0]   set_addr,
  input  logic            clr_en,
  input  logic [AW-1:0]   clr_addr,
  input  logic [AW-1:0]   look_a,
  input  logic [AW-1:0]   look_b,
  input  logic [AW-1:0]   look_c,
  output logic [NREG-1:0] busy,
  output logic            hit_a,
  output logic            hit_b,
  output logic            hit_c
);

  logic [NREG-1:0] busy_reg;
  logic [NREG-1:0] busy_next;

  // A set in the same cycle as a clear of the same entry wins; entry 0 never holds.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_bit
      if (gi == 0) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_live
        assign busy_next[gi] = (set_en && (set_addr == AW'(gi))) ||
                               (busy_reg[gi] && !(clr_en && (clr_addr == AW'(gi))));
      end
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign busy  = busy_reg;
  assign hit_a = busy_reg[look_a];
  assign hit_b = busy_reg[look_b];
  assign hit_c = busy_reg[look_c];

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates the single register-file write port between load return, jal link
// and ALU results, with an anti-starvation boost for the ALU and a load-busy stall.
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int DW         = DATA_W,
  parameter int AW         = ADDR_W
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_addr,
  input  logic [DW-1:0]   alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [AW-1:0]   mem_addr,
  input  logic [DW-1:0]   mem_data,
  output logic            mem_ready,
  input  logic            lnk_valid,
  input  logic [DW-1:0]   lnk_data,
  output logic            lnk_ready,
  input  logic            iss_load,
  input  logic [AW-1:0]   iss_rd,
  input  logic [AW-1:0]   dec_rs,
  input  logic [AW-1:0]   dec_rt,
  input  logic [AW-1:0]   dec_rd,
  output logic            stall,
  output logic            wr_en,
  output logic [AW-1:0]   wr_addr,
  output logic [DW-1:0]   wr_data,
  output logic [NREG-1:0] busy_vec
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0]   starve_reg;
  logic            alu_force;
  logic [NREQ-1:0] grant;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;
  logic            hit_rs;
  logic            hit_rt;
  logic            hit_rd;

  // Fixed priority MEM > LNK > ALU, unless the ALU has lost STARVE_MAX cycles in a row.
  always_comb begin
    alu_force      = alu_valid && (starve_reg == SW'(STARVE_MAX));
    grant          = '0;
    grant[REQ_MEM] = mem_valid && !alu_force;
    grant[REQ_LNK] = lnk_valid && !mem_valid && !alu_force;
    grant[REQ_ALU] = alu_valid && (alu_force || !(mem_valid || lnk_valid));
    win_addr       = alu_addr;
    win_data       = alu_data;
    if (grant[REQ_MEM]) begin
      win_addr = mem_addr;
      win_data = mem_data;
    end else if (grant[REQ_LNK]) begin
      win_addr = AW'(REG_LINK);
      win_data = lnk_data;
    end
  end

  assign mem_ready = grant[REQ_MEM];
  assign lnk_ready = grant[REQ_LNK];
  assign alu_ready = grant[REQ_ALU];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_reg <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      if (alu_valid && !grant[REQ_ALU]) begin
        if (starve_reg != SW'(STARVE_MAX)) starve_reg <= starve_reg + 1'b1;
      end else begin
        starve_reg <= '0;
      end
      // Writes to register 0 complete the handshake but never reach the file.
      wr_en <= (|grant) && (win_addr != '0);
      if (|grant) begin
        wr_addr <= win_addr;
        wr_data <= win_data;
      end
    end
  end

  regfile_wb_scheduler_wb_scoreboard #(
    .AW(AW)
  ) u_scoreboard (
    .clock    (clock),
    .reset    (reset),
    .set_en   (iss_load),
    .set_addr (iss_rd),
    .clr_en   (grant[REQ_MEM]),
    .clr_addr (mem_addr),
    .look_a   (dec_rs),
    .look_b   (dec_rt),
    .look_c   (dec_rd),
    .busy     (busy_vec),
    .hit_a    (hit_rs),
    .hit_b    (hit_rt),
    .hit_c    (hit_rd)
  );

  assign stall = hit_rs | hit_rt | hit_rd;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed scenarios plus random traffic against a queue-based writeback model.
module tb_regfile_wb_scheduler;
  localparam int STARVE_MAX = 4;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          alu_valid = 0, mem_valid = 0, lnk_valid = 0, iss_load = 0;
  logic [AW-1:0] alu_addr = 0, mem_addr = 0, iss_rd = 0, dec_rs = 0, dec_rt = 0, dec_rd = 0;
  logic [DW-1:0] alu_data = 0, mem_data = 0, lnk_data = 0;
  logic          alu_ready, mem_ready, lnk_ready, stall, wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [31:0]   busy_vec;

  always #5 clock = ~clock;

  regfile_wb_scheduler #(.STARVE_MAX(STARVE_MAX), .DW(DW), .AW(AW)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .lnk_valid(lnk_valid), .lnk_data(lnk_data), .lnk_ready(lnk_ready),
    .iss_load(iss_load), .iss_rd(iss_rd),
    .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_rd(dec_rd),
    .stall(stall), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy_vec(busy_vec)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t       exp_q[$];
  bit [31:0] m_busy = '0;
  int        m_lost = 0;
  bit        acc_mem, acc_lnk, acc_alu;
  int        n_vec = 0;
  int        n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock of traffic: inputs are already driven; the model predicts the grant.
  task automatic step();
    bit  force_alu, em, el, ea;
    bit [31:0] nb;
    wr_t w;
    @(negedge clock);
    force_alu = alu_valid && (m_lost >= STARVE_MAX);
    em = mem_valid && !force_alu;
    el = lnk_valid && !em && !force_alu;
    ea = alu_valid && !em && !el;
    check("ready", {61'd0, mem_ready, lnk_ready, alu_ready}, {61'd0, em, el, ea});
    check("stall", {63'd0, stall}, {63'd0, m_busy[dec_rs] | m_busy[dec_rt] | m_busy[dec_rd]});
    check("busy_vec", {32'd0, busy_vec}, {32'd0, m_busy});
    if (em) begin
      $display("t=%0t grant mem addr=%0d data=%h", $time, mem_addr, mem_data);
      w.addr = mem_addr; w.data = mem_data;
      if (mem_addr != 0) exp_q.push_back(w);
    end else if (el) begin
      $display("t=%0t grant lnk addr=31 data=%h", $time, lnk_data);
      w.addr = 5'd31; w.data = lnk_data;
      exp_q.push_back(w);
    end else if (ea) begin
      $display("t=%0t grant alu addr=%0d data=%h", $time, alu_addr, alu_data);
      w.addr = alu_addr; w.data = alu_data;
      if (alu_addr != 0) exp_q.push_back(w);
    end
    nb = m_busy;
    if (em) nb[mem_addr] = 1'b0;
    if (iss_load) nb[iss_rd] = 1'b1;
    nb[0] = 1'b0;
    m_busy = nb;
    if (alu_valid && !ea) m_lost = (m_lost < STARVE_MAX) ? m_lost + 1 : STARVE_MAX;
    else m_lost = 0;
    acc_mem = em; acc_lnk = el; acc_alu = ea;
    @(posedge clock);
    #1;
  endtask

  task automatic release_accepted();
    if (acc_mem) mem_valid = 1'b0;
    if (acc_lnk) lnk_valid = 1'b0;
    if (acc_alu) alu_valid = 1'b0;
  endtask

  // Monitor: every write seen on the port must be the next expected one.
  initial begin
    wr_t e;
    wait (reset === 1'b1);
    forever begin
      @(posedge clock);
      #2;
      if (wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_write: got addr=%0d data=%h expected no write", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", {59'd0, wr_addr}, {59'd0, e.addr});
          check("wr_data", {32'd0, wr_data}, {32'd0, e.data});
        end
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_vec++; n_err++;
        $display("FAIL missing_write: got wr_en=%b expected write addr=%0d data=%h", wr_en, e.addr, e.data);
      end
    end
  end

  initial begin
    int alu_cycle;
    int r;
    // Reset held with every requester active
    alu_valid = 1; alu_addr = 7; alu_data = 32'h1111_0007;
    mem_valid = 1; mem_addr = 4; mem_data = 32'h2222_0004;
    lnk_valid = 1; lnk_data = 32'h0040_0000;
    iss_load = 1; iss_rd = 6;
    repeat (3) begin
      @(negedge clock);
      check("reset_wr_en", {63'd0, wr_en}, 64'd0);
      check("reset_busy", {32'd0, busy_vec}, 64'd0);
    end
    iss_load = 0;
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (3) begin step(); release_accepted(); end
    step();

    // Single ALU write
    alu_valid = 1; alu_addr = 5; alu_data = 32'hDEAD_BEEF;
    step(); release_accepted(); step();

    // Contention: ALU starves for STARVE_MAX cycles then wins once
    alu_valid = 1; alu_addr = 3; alu_data = 32'hA5A5_0003;
    mem_valid = 1; mem_addr = 10;
    alu_cycle = 0;
    for (int i = 1; i <= 6; i++) begin
      mem_data = 32'h3000_0000 + i;
      step();
      if (acc_alu) begin alu_cycle = i; alu_valid = 0; end
    end
    check("starve_grant_cycle", 64'(alu_cycle), 64'(STARVE_MAX + 1));
    mem_valid = 0; step();

    // Load scoreboard and stall release
    iss_load = 1; iss_rd = 8; step();
    iss_load = 0; dec_rs = 8; step();
    check("stall_on_busy", {63'd0, stall}, 64'd1);
    mem_valid = 1; mem_addr = 8; mem_data = 32'h1234_5678;
    step(); release_accepted(); step();
    check("stall_cleared", {63'd0, stall}, 64'd0);
    dec_rs = 0;

    // Set/clear collision: set wins
    mem_valid = 1; mem_addr = 9; mem_data = 32'h0000_0909;
    iss_load = 1; iss_rd = 9;
    step(); release_accepted(); iss_load = 0; step();
    check("collision_busy9", {63'd0, busy_vec[9]}, 64'd1);
    mem_valid = 1; mem_addr = 9; mem_data = 32'h0000_9999;
    step(); release_accepted(); step();

    // Register 0 and link
    alu_valid = 1; alu_addr = 0; alu_data = 32'hFFFF_FFFF;
    step(); release_accepted(); step();
    check("r0_no_write", {63'd0, wr_en}, 64'd0);
    lnk_valid = 1; lnk_data = 32'h0040_0010;
    step(); release_accepted(); step();

    // Random traffic
    for (int c = 0; c < 500; c++) begin
      if (!mem_valid && ($urandom_range(0, 3) == 0)) begin
        mem_valid = 1; mem_addr = AW'($urandom_range(0, 31)); mem_data = $urandom;
      end
      if (!lnk_valid && ($urandom_range(0, 5) == 0)) begin
        lnk_valid = 1; lnk_data = $urandom;
      end
      if (!alu_valid && ($urandom_range(0, 1) == 0)) begin
        alu_valid = 1; alu_addr = AW'($urandom_range(0, 31)); alu_data = $urandom;
      end
      r = $urandom_range(1, 31);
      iss_load = ($urandom_range(0, 3) == 0) && !m_busy[r];
      iss_rd = AW'(r);
      dec_rs = AW'($urandom_range(0, 31));
      dec_rt = AW'($urandom_range(0, 31));
      dec_rd = AW'($urandom_range(0, 31));
      step();
      release_accepted();
    end

    alu_valid = 0; mem_valid = 0; lnk_valid = 0; iss_load = 0;
    repeat (3) step();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
